// File: rtl/keypad_entry_ctrl_if.sv
// Signal bundle between the keypad scanner, the entry controller and the FND pins.
// The controller takes the slave view; the scanner/board side takes the master view.
interface keypad_entry_ctrl_if;
   logic [7:0]  key_data;     // scanner code, 8'h00 when no key is down
   logic        fnd_en;       // display enable, active-high
   logic [3:0]  fnd_sel;      // one-hot active-low digit select, bit0 = rightmost
   logic [7:0]  fnd_data;     // segments {dp,g,f,e,d,c,b,a}, active-high
   logic [15:0] value;        // last committed entry, 4 BCD nibbles
   logic        value_valid;  // one-cycle pulse when value updates
   logic [2:0]  digit_cnt;    // digits currently buffered, 0..4
   logic [7:0]  led;          // last accepted key code

   modport slave (
      input  key_data,
      output fnd_en, fnd_sel, fnd_data, value, value_valid, digit_cnt, led
   );

   modport master (
      output key_data,
      input  fnd_en, fnd_sel, fnd_data, value, value_valid, digit_cnt, led
   );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces scanner codes, acts once per press
// (digits shift into a 4-digit BCD buffer, '*' clears, '#' commits), and
// drives a multiplexed 4-digit FND scan of the buffer.
// Optional build macro ENTRY_TIMEOUT_EN adds an idle auto-clear of the buffer.
module keypad_entry_ctrl #(
   parameter int DEB_CYCLES     = 100000,
   parameter int SCAN_DIV       = 50000
`ifdef ENTRY_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 250000000
`endif
) (
   input  logic                clk,
   input  logic                reset,
   keypad_entry_ctrl_if.slave  bus
);

   localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEB_PRESS,
      S_ACT,
      S_WAIT_REL
   } state_t;

   typedef enum logic [1:0] {
      K_NONE,
      K_DIGIT,
      K_CLEAR,
      K_COMMIT
   } key_kind_t;

   typedef struct packed {
      key_kind_t  kind;
      logic [3:0] bcd;
   } key_dec_t;

   // Map a scanner code to its meaning; unknown nonzero codes are K_NONE.
   function automatic key_dec_t decode_key(input logic [7:0] code);
      key_dec_t d;
      d.kind = K_DIGIT;
      d.bcd  = 4'd0;
      case (code)
         8'ha0:   d.bcd  = 4'd0;
         8'h01:   d.bcd  = 4'd1;
         8'h02:   d.bcd  = 4'd2;
         8'h04:   d.bcd  = 4'd3;
         8'h08:   d.bcd  = 4'd4;
         8'h10:   d.bcd  = 4'd5;
         8'h20:   d.bcd  = 4'd6;
         8'h40:   d.bcd  = 4'd7;
         8'h80:   d.bcd  = 4'd8;
         8'h90:   d.bcd  = 4'd9;
         8'hb0:   d.kind = K_CLEAR;
         8'hc0:   d.kind = K_COMMIT;
         default: d.kind = K_NONE;
      endcase
      return d;
   endfunction

   // BCD digit to active-high segment pattern {dp,g,f,e,d,c,b,a}.
   function automatic logic [7:0] seg7(input logic [3:0] bcd);
      logic [7:0] s;
      case (bcd)
         4'd0:    s = 8'h3f;
         4'd1:    s = 8'h06;
         4'd2:    s = 8'h5b;
         4'd3:    s = 8'h4f;
         4'd4:    s = 8'h66;
         4'd5:    s = 8'h6d;
         4'd6:    s = 8'h7d;
         4'd7:    s = 8'h07;
         4'd8:    s = 8'h7f;
         4'd9:    s = 8'h6f;
         default: s = 8'h00;
      endcase
      return s;
   endfunction

   logic [7:0]        k_q;
   logic [7:0]        cand;
   logic [DEB_W-1:0]  deb_cnt;
   state_t            state, next_state;
   logic              act;
   key_dec_t          act_key;

   logic [15:0]       buffer;
   logic [2:0]        digit_cnt;
   logic [15:0]       value;
   logic              value_valid;
   logic [7:0]        led;

   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        idx;
   logic [7:0]        seg_next;
   logic              fnd_en;
   logic [3:0]        fnd_sel;
   logic [7:0]        fnd_data;

   assign act_key = decode_key(cand);

   // Register the raw scanner code once; all debounce decisions use k_q.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) k_q <= 8'h00;
      else       k_q <= bus.key_data;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // FSM next-state and action strobe.
   // NOTE: every output of this block is defaulted first so no path infers a latch.
   always_comb begin
      next_state = state;
      act        = 1'b0;
      case (state)
         S_IDLE: begin
            if (k_q != 8'h00) next_state = S_DEB_PRESS;
         end
         S_DEB_PRESS: begin
            if (k_q != cand)              next_state = S_IDLE;
            else if (deb_cnt == DEB_LAST) next_state = S_ACT;
         end
         S_ACT: begin
            act        = 1'b1;
            next_state = S_WAIT_REL;
         end
         S_WAIT_REL: begin
            if (k_q == 8'h00 && deb_cnt == DEB_LAST) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Candidate latch and shared press/release stability counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand    <= 8'h00;
         deb_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               deb_cnt <= '0;
               if (k_q != 8'h00) cand <= k_q;
            end
            S_DEB_PRESS: begin
               if (k_q == cand && deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + DEB_W'(1);
            end
            S_ACT: begin
               deb_cnt <= '0;
            end
            S_WAIT_REL: begin
               // Any nonzero code (same or different key) restarts the release window.
               if (k_q != 8'h00)             deb_cnt <= '0;
               else if (deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + DEB_W'(1);
            end
            default: deb_cnt <= '0;
         endcase
      end
   end

`ifdef ENTRY_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] idle_cnt;
   logic             timeout_hit;

   // An action in the same cycle wins over the timeout.
   assign timeout_hit = (digit_cnt != 3'd0) && (idle_cnt == TMO_LAST) && !act;

   // Idle counter: runs while digits are pending, restarts on every action.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          idle_cnt <= '0;
      else if (act || digit_cnt == 3'd0 || timeout_hit)   idle_cnt <= '0;
      else                                                idle_cnt <= idle_cnt + TMO_W'(1);
   end
`endif

   // Entry buffer, committed value and key LED, updated on the action cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buffer      <= 16'h0000;
         digit_cnt   <= 3'd0;
         value       <= 16'h0000;
         value_valid <= 1'b0;
         led         <= 8'h00;
      end else begin
         value_valid <= 1'b0;
         if (act) begin
            case (act_key.kind)
               K_DIGIT: begin
                  // Oldest digit falls off the top once four are buffered.
                  buffer <= {buffer[11:0], act_key.bcd};
                  if (digit_cnt != 3'd4) digit_cnt <= digit_cnt + 3'd1;
                  led    <= cand;
               end
               K_CLEAR: begin
                  buffer    <= 16'h0000;
                  digit_cnt <= 3'd0;
                  led       <= cand;
               end
               K_COMMIT: begin
                  value       <= buffer;
                  value_valid <= 1'b1;
                  buffer      <= 16'h0000;
                  digit_cnt   <= 3'd0;
                  led         <= cand;
               end
               default: ;
            endcase
         end
`ifdef ENTRY_TIMEOUT_EN
         else if (timeout_hit) begin
            buffer    <= 16'h0000;
            digit_cnt <= 3'd0;
         end
`endif
      end
   end

   // Free-running scan divider stepping the selected digit position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= 2'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Segment pattern for the current position: blank leading digits, dash when empty.
   always_comb begin
      seg_next = 8'h00;
      if (digit_cnt == 3'd0) begin
         if (idx == 2'd0) seg_next = 8'h40;
      end else if ({1'b0, idx} < digit_cnt) begin
         seg_next = seg7(buffer[{idx, 2'b00} +: 4]);
      end
   end

   // Registered display outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fnd_en   <= 1'b0;
         fnd_sel  <= 4'hF;
         fnd_data <= 8'h00;
      end else begin
         fnd_en   <= 1'b1;
         fnd_sel  <= ~(4'b0001 << idx);
         fnd_data <= seg_next;
      end
   end

   assign bus.fnd_en      = fnd_en;
   assign bus.fnd_sel     = fnd_sel;
   assign bus.fnd_data    = fnd_data;
   assign bus.value       = value;
   assign bus.value_valid = value_valid;
   assign bus.digit_cnt   = digit_cnt;
   assign bus.led         = led;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Testbench for keypad_entry_ctrl: directed cases plus randomized key
// sequences against a digit-list reference model; commits are scoreboarded
// and checked by an independent value_valid monitor.
module tb_keypad_entry_ctrl;

   localparam int DEB  = 8;
   localparam int SCAN = 4;
   localparam int TMO  = 50;

   localparam logic [7:0] DIGIT_CODE [10] = '{8'ha0, 8'h01, 8'h02, 8'h04, 8'h08,
                                             8'h10, 8'h20, 8'h40, 8'h80, 8'h90};
   localparam logic [7:0] SEG_TAB [10]    = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66,
                                             8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};
   localparam logic [7:0] KEY_STAR = 8'hb0;
   localparam logic [7:0] KEY_HASH = 8'hc0;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   keypad_entry_ctrl_if bus ();

   keypad_entry_ctrl #(
      .DEB_CYCLES     (DEB),
      .SCAN_DIV       (SCAN)
`ifdef ENTRY_TIMEOUT_EN
      ,.TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   int          digits [$];   // buffered digits, oldest first
   logic [7:0]  m_led;
   logic [15:0] m_value;
   logic [15:0] exp_q [$];    // commits awaiting a value_valid pulse

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int digit_of(input logic [7:0] code);
      int d;
      d = -1;
      for (int i = 0; i < 10; i++) if (DIGIT_CODE[i] == code) d = i;
      return d;
   endfunction

   function automatic bit is_valid_code(input logic [7:0] code);
      return (digit_of(code) >= 0) || (code == KEY_STAR) || (code == KEY_HASH);
   endfunction

   // Effect of one accepted press on the model.
   task automatic model_apply(input logic [7:0] code);
      int          d;
      logic [15:0] v;
      d = digit_of(code);
      if (d >= 0) begin
         digits.push_back(d);
         if (digits.size() > 4) void'(digits.pop_front());
         m_led = code;
      end else if (code == KEY_STAR) begin
         digits.delete();
         m_led = code;
      end else if (code == KEY_HASH) begin
         v = 16'h0000;
         foreach (digits[i]) v = (v << 4) | 16'(digits[i]);
         exp_q.push_back(v);
         m_value = v;
         digits.delete();
         m_led = code;
      end
   endtask

   function automatic logic [7:0] exp_seg(input int p);
      int n;
      n = digits.size();
      if (n == 0) return (p == 0) ? 8'h40 : 8'h00;
      if (p < n)  return SEG_TAB[digits[n - 1 - p]];
      return 8'h00;
   endfunction

   task automatic press(input logic [7:0] code, input int hold, input int rel);
      bus.key_data = code;
      tick(hold);
      bus.key_data = 8'h00;
      tick(rel);
   endtask

   task automatic check_state(input string tag);
      check({tag, " digit_cnt"}, 32'(bus.digit_cnt), 32'(digits.size()));
      check({tag, " led"}, 32'(bus.led), 32'(m_led));
      check({tag, " value"}, 32'(bus.value), 32'(m_value));
   endtask

   // Sweep a full scan cycle and compare each selected position with the model.
   task automatic check_display(input string tag);
      int         p;
      logic [3:0] onehot;
      for (int c = 0; c < 4 * SCAN + 2; c++) begin
         @(negedge clk);
         p = -1;
         for (int q = 0; q < 4; q++) begin
            onehot = 4'b0001 << q;
            if (bus.fnd_sel == ~onehot) p = q;
         end
         if (p < 0) check({tag, " fnd_sel one-hot"}, 32'(bus.fnd_sel), 32'hE);
         else       check($sformatf("%s pos%0d", tag, p), 32'(bus.fnd_data), 32'(exp_seg(p)));
      end
      check({tag, " fnd_en"}, 32'(bus.fnd_en), 32'h1);
   endtask

   // Commit monitor: every value_valid pulse must match the oldest pending commit.
   logic prev_vv = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         prev_vv = 1'b0;
      end else begin
         if (prev_vv) check("value_valid width", 32'(bus.value_valid), 32'h0);
         if (bus.value_valid) begin
            if (exp_q.size() == 0) check("value_valid with no commit pending", 32'(bus.value_valid), 32'h0);
            else                   check("committed value", 32'(bus.value), 32'(exp_q.pop_front()));
         end
         prev_vv = bus.value_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] code;
      logic [7:0] code_b;
      int         sel;

      bus.key_data = 8'h00;
      m_led   = 8'h00;
      m_value = 16'h0000;

      // Power-up reset values
      tick(3);
      check("por fnd_sel", 32'(bus.fnd_sel), 32'hF);
      check("por fnd_en", 32'(bus.fnd_en), 32'h0);
      check("por digit_cnt", 32'(bus.digit_cnt), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("fnd_en after reset release", 32'(bus.fnd_en), 32'h1);

      // Test 1: accept a key, then reset in the middle of the next debounce
      model_apply(8'h01);
      press(8'h01, 20, 20);
      check_state("pre-reset");
      bus.key_data = 8'h01;
      tick(5);
      #2 reset = 1'b1;
      #1;
      check("reset fnd_en", 32'(bus.fnd_en), 32'h0);
      check("reset fnd_sel", 32'(bus.fnd_sel), 32'hF);
      check("reset fnd_data", 32'(bus.fnd_data), 32'h0);
      check("reset value", 32'(bus.value), 32'h0);
      check("reset value_valid", 32'(bus.value_valid), 32'h0);
      check("reset digit_cnt", 32'(bus.digit_cnt), 32'h0);
      check("reset led", 32'(bus.led), 32'h0);
      digits.delete();
      m_led = 8'h00;
      tick(2);
      bus.key_data = 8'h00;
      tick(2);
      reset = 1'b0;
      tick(2);
      check_state("post-reset");

`ifdef ENTRY_TIMEOUT_EN
      // Test 6 (timeout build): one digit, then idle past the timeout
      model_apply(DIGIT_CODE[5]);
      press(DIGIT_CODE[5], 20, 20);
      check("timeout pre digit_cnt", 32'(bus.digit_cnt), 32'h1);
      tick(60);
      digits.delete();
      check_state("after timeout");

      // Commit with gaps short enough that the timeout never fires
      for (int i = 9; i >= 5; i--) begin
         model_apply(DIGIT_CODE[i]);
         press(DIGIT_CODE[i], 12, 12);
      end
      model_apply(KEY_HASH);
      press(KEY_HASH, 12, 12);
      check("commit 8765", 32'(bus.value), 32'h8765);
      check_state("commit");
      check_display("commit");
`else
      // Test 2: enter 1, 2, 3
      for (int i = 1; i <= 3; i++) begin
         model_apply(DIGIT_CODE[i]);
         press(DIGIT_CODE[i], 20, 20);
      end
      check("t2 digit_cnt", 32'(bus.digit_cnt), 32'h3);
      check_state("t2");
      check_display("t2");

      // Test 3: short bounce on key 08 is ignored
      press(8'h08, 3, 20);
      check_state("t3 bounce");

      // Test 4: 9 8 7 6 5 then '#'
      for (int i = 9; i >= 5; i--) begin
         model_apply(DIGIT_CODE[i]);
         press(DIGIT_CODE[i], 20, 20);
      end
      check_display("t4 full");
      model_apply(KEY_HASH);
      press(KEY_HASH, 20, 20);
      check("t4 value", 32'(bus.value), 32'h8765);
      check_state("t4");
      check_display("t4 empty");

      // Test 5: 4, 2, '*', then an invalid code
      model_apply(DIGIT_CODE[4]);
      press(DIGIT_CODE[4], 20, 20);
      model_apply(DIGIT_CODE[2]);
      press(DIGIT_CODE[2], 20, 20);
      model_apply(KEY_STAR);
      press(KEY_STAR, 20, 20);
      check_state("t5 clear");
      press(8'h03, 20, 20);
      check_state("t5 invalid");
      model_apply(DIGIT_CODE[7]);
      press(DIGIT_CODE[7], 20, 20);
      check_state("t5 after invalid");

      // A second key pressed while the first is still held gets no action
      model_apply(DIGIT_CODE[1]);
      bus.key_data = DIGIT_CODE[1];
      tick(20);
      bus.key_data = DIGIT_CODE[2];
      tick(20);
      bus.key_data = 8'h00;
      tick(20);
      check_state("key switch");

      // '#' on an empty buffer still commits 0000
      model_apply(KEY_STAR);
      press(KEY_STAR, 20, 20);
      model_apply(KEY_HASH);
      press(KEY_HASH, 20, 20);
      check_state("empty commit");

      // Test 6 (default build): buffer persists with no timeout
      model_apply(DIGIT_CODE[5]);
      press(DIGIT_CODE[5], 20, 20);
      tick(60);
      check("t6 digit_cnt", 32'(bus.digit_cnt), 32'h1);

      // Randomized key sequences
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 15);
         if (sel <= 9) begin
            code = DIGIT_CODE[sel];
            model_apply(code);
            press(code, $urandom_range(14, 30), $urandom_range(20, 26));
         end else if (sel == 10 || sel == 11 || sel == 12) begin
            code = (sel == 10) ? KEY_STAR : KEY_HASH;
            model_apply(code);
            press(code, $urandom_range(14, 30), $urandom_range(20, 26));
         end else if (sel == 13) begin
            code = 8'($urandom_range(1, 255));
            while (is_valid_code(code)) code = 8'($urandom_range(1, 255));
            press(code, $urandom_range(14, 30), $urandom_range(20, 26));
         end else if (sel == 14) begin
            code = DIGIT_CODE[$urandom_range(0, 9)];
            press(code, $urandom_range(1, 3), 20);
         end else begin
            code   = DIGIT_CODE[$urandom_range(0, 9)];
            code_b = DIGIT_CODE[$urandom_range(0, 9)];
            model_apply(code);
            bus.key_data = code;
            tick($urandom_range(14, 24));
            bus.key_data = code_b;
            tick($urandom_range(10, 20));
            bus.key_data = 8'h00;
            tick(20);
         end
         check_state($sformatf("rand%0d", n));
         if (n % 4 == 0) check_display($sformatf("rand%0d", n));
      end
`endif

      tick(4);
      check("pending commits drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences keypad entry into a 4-digit decimal buffer and schedules the multiplexed 4-digit FND scan. Accepts the 8-bit key code from the keypad scanner, debounces it, and acts once per press: digits shift in, `*` clears, `#` commits. Sits between the keypad scanner and the FND pins, and replaces the single-digit direct decode in the top level.

Parameters:
- DEB_CYCLES, 100000: consecutive stable cycles required before a press or a release is accepted.
- SCAN_DIV, 50000: clock cycles each FND digit stays selected.
- TIMEOUT_CYCLES, 250000000: idle cycles before auto-clear (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_data  input  8  scanner code: 0=a0, 1=01, 2=02, 3=04, 4=08, 5=10, 6=20, 7=40, 8=80, 9=90, `*`=b0, `#`=c0, idle=00
- fnd_en  output  1  display enable, active-high
- fnd_sel  output  4  digit select, one-hot active-low; bit0 is the rightmost digit
- fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-high
- value  output  16  last committed entry, 4 BCD nibbles, [15:12] most significant
- value_valid  output  1  one-cycle pulse when value updates
- digit_cnt  output  3  digits currently in buffer, 0..4
- led  output  8  last accepted key code

Behaviour:
- Reset (async, any time including mid-debounce): FSM=IDLE, buffer=0, digit_cnt=0, value=0, value_valid=0, led=0, scan index=0, fnd_en=0, fnd_sel=4'hF, fnd_data=0, all counters=0.
- key_data is registered once (k_q) before any use. All debounce comparisons use k_q.
- FSM states:
  - IDLE: k_q!=0 -> DEB_PRESS; the candidate is latched and the counter cleared.
  - DEB_PRESS: counter increments while k_q==candidate. If k_q differs, return to IDLE. When counter reaches DEB_CYCLES-1, go to ACT.
  - ACT: one cycle. Execute the action, then go to WAIT_REL.
  - WAIT_REL: counter increments while k_q==0 and resets on any nonzero value. At DEB_CYCLES-1, go to IDLE.
- Exactly one action per press regardless of hold length. A different key pressed while in WAIT_REL is ignored.
- ACT actions (led <= candidate for every valid code):
  - Digit: buffer <= {buffer[11:0], bcd}; digit_cnt <= min(digit_cnt+1, 4). At 4 digits the oldest digit is dropped.
  - `*`: buffer=0, digit_cnt=0.
  - `#`: value <= buffer; value_valid=1 for one cycle (the cycle after ACT); buffer=0, digit_cnt=0. `#` with digit_cnt=0 still commits 0000 and pulses.
  - Any other nonzero code: no action, led unchanged, FSM still goes to WAIT_REL.
- Scan scheduler:
  - Free-running divider; scan index (0..3) advances and wraps every SCAN_DIV cycles.
  - fnd_sel = ~(4'b0001 << idx).
  - fnd_en=1 from the first cycle after reset release.
- Display data:
  - Position idx shows buffer nibble idx through the 0-9 segment table (3f, 06, 5b, 4f, 66, 6d, 7d, 07, 7f, 6f) if idx < digit_cnt, else 8'h00 (blank leading digits).
  - With digit_cnt=0, position 0 shows 8'h40 (dash).
  - Display outputs are registered: they update one cycle after the idx or buffer change.
- A buffer update in the same cycle as a scan step is allowed: the new digit appears on the next registered update.

Optional Feature:
- ENTRY_TIMEOUT_EN defined: an idle counter runs while digit_cnt>0 and resets on every ACT. At TIMEOUT_CYCLES-1 the buffer and digit_cnt are cleared, with no value_valid pulse.
- Undefined: no idle counter is built, and the buffer persists indefinitely.

Test Plan:
All cases use DEB_CYCLES=8, SCAN_DIV=4.
1. Reset asserted mid-DEB_PRESS with key 01 held -> all outputs at reset values immediately; fnd_sel=F, value=0000.
2. Keys 1, 2, 3 each held 20 cycles, released 20 cycles -> digit_cnt=3, buffer=0123. Scan shows position0=4f, position1=5b, position2=06, position3=00.
3. Key 08 held 3 cycles then released (bounce) -> no action; digit_cnt unchanged, led unchanged.
4. Enter 9, 8, 7, 6, 5 then `#` -> value=16'h8765, value_valid high exactly 1 cycle, digit_cnt=0, position0 shows 40.
5. Enter 4, 2, then `*`, then key code 0x03 (invalid) -> digit_cnt=0 after `*`; invalid code causes no change, and WAIT_REL is entered.
6. With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=50, enter 5 and idle 60 cycles -> digit_cnt=0 and value_valid never asserts. Without the macro, digit_cnt stays 1.
